// File: rtl/inj_pkg.sv
// Shared types and helpers for the injection scheduler.
// Holds the FSM encoding, flit layout and the clog2 helper.
package inj_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PRIME,
    S_STREAM,
    S_DONE
  } state_e;

  localparam int FLIT_W   = 20;
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 4;
  localparam int PAY_LSB  = 4;
  localparam int PAY_W    = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/inj_rr_pick.sv
// Combinational round-robin finder: first eligible
// source at or after ptr_i, wrapping around.
module inj_rr_pick
  import inj_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  int best;
  int d;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    best    = N;
    d       = 0;
    for (int j = 0; j < N; j++) begin
      if (elig_i[j]) begin
        d = (j + N - int'(ptr_i)) % N;
        if (d < best) begin
          best    = d;
          idx_o   = IW'(j);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inj_sched.sv
// Round-robin injection scheduler for one router local port.
// Optional sticky protocol checker: INJ_SCHED_ERR_CHK_EN.
module inj_sched
  import inj_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DW        = 20,
  parameter int SRC_DEPTH = 30,
  parameter int QUANTUM   = 4,
  parameter int CREDITS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_SRC-1:0]   src_en,
  input  logic [N_SRC*DW-1:0] src_data,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic               credit_ret,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  output logic               all_done,
  output logic               err
);

  localparam int IW = clog2(N_SRC);
  localparam int WW = clog2(SRC_DEPTH + 1);
  localparam int QW = clog2(QUANTUM + 1);
  localparam int CW = clog2(CREDITS + 1);

  localparam logic [WW-1:0] DMAX = WW'(SRC_DEPTH);
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [IW-1:0] LAST = IW'(N_SRC - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [QW-1:0]     quota_q, quota_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [WW-1:0]     word_q [N_SRC];
  logic [WW-1:0]     word_d [N_SRC];
  logic [N_SRC-1:0]  primed_q, primed_d;
  logic [IW-1:0]     sel_q;
  logic              pend_q;
  logic [DW-1:0]     odata_q;
  logic              ovalid_q;

  logic [N_SRC-1:0]  elig;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic              take;
  logic              go;
  logic [CW:0]       cred_sum;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = word_q[i] < DMAX;
    end
  end

  inj_rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign go = start && (credit_q != '0)
           && (quota_q < QMAX)
           && (word_q[cur_q] < DMAX);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_d     = rr_q;
    quota_d  = quota_q;
    word_d   = word_q;
    primed_d = primed_q;
    src_en   = '0;
    take     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (!pick_found) begin
          state_d = S_DONE;
        end else begin
          cur_d   = pick_idx;
          quota_d = '0;
          rr_d    = (pick_idx == LAST) ? '0
                  : pick_idx + 1'b1;
          state_d = primed_q[pick_idx] ? S_STREAM
                  : S_PRIME;
        end
      end
      S_PRIME: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          src_en[cur_q]   = 1'b1;
          primed_d[cur_q] = 1'b1;
          state_d         = S_STREAM;
        end
      end
      S_STREAM: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (go) begin
          src_en[cur_q] = 1'b1;
          take          = 1'b1;
          quota_d       = quota_q + 1'b1;
          word_d[cur_q] = word_q[cur_q] + 1'b1;
          if (quota_d == QMAX
              || word_d[cur_q] == DMAX)
            state_d = S_SELECT;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Returns saturate so a spurious credit cannot overfill.
  always_comb begin
    cred_sum = {1'b0, credit_q}
             - {{CW{1'b0}}, take}
             + {{CW{1'b0}}, credit_ret};
    credit_d = (cred_sum > {1'b0, CMAX}) ? CMAX
             : cred_sum[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      rr_q     <= '0;
      quota_q  <= '0;
      credit_q <= CMAX;
      primed_q <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rr_q     <= rr_d;
      quota_q  <= quota_d;
      credit_q <= credit_d;
      primed_q <= primed_d;
      word_q   <= word_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q    <= '0;
      pend_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      sel_q    <= cur_q;
      pend_q   <= take;
      ovalid_q <= src_valid[sel_q] & pend_q;
      if (src_valid[sel_q] && pend_q)
        odata_q <= src_data[sel_q*DW +: DW];
    end
  end

  assign out_data  = odata_q;
  assign out_valid = ovalid_q;
  assign all_done  = (state_q == S_DONE);

`ifdef INJ_SCHED_ERR_CHK_EN
  logic err_q;
  logic err_hit;

  always_comb begin
    err_hit = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_valid[i]
          && (!pend_q || IW'(i) != sel_q))
        err_hit = 1'b1;
    end
    if (pend_q && !src_valid[sel_q])
      err_hit = 1'b1;
    if (credit_ret && credit_q == CMAX)
      err_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inj_sched.sv
// Self-checking bench for inj_sched with ROM source models
// and a latency/round-robin reference model.
module tb_inj_sched;
  import inj_pkg::*;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int D  = 30;
  localparam int Q  = 4;
  localparam int C  = 4;
`ifdef INJ_SCHED_ERR_CHK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          credit_ret = 1'b0;
  logic [N-1:0]  src_en;
  logic [N-1:0]  src_valid;
  logic [N*DW-1:0] src_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          all_done;
  logic          err;

  always #5 clk = ~clk;

  inj_sched #(
    .N_SRC(N), .DW(DW), .SRC_DEPTH(D),
    .QUANTUM(Q), .CREDITS(C)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_en(src_en), .src_data(src_data),
    .src_valid(src_valid),
    .credit_ret(credit_ret),
    .out_data(out_data), .out_valid(out_valid),
    .all_done(all_done), .err(err)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic flit_t rom(int s, int k);
    flit_t f;
    f = '0;
    f[PAY_LSB +: PAY_W]   = {8'(s + 1), 8'(k + 1)};
    f[DEST_LSB +: DEST_W] = 4'(k);
    return f;
  endfunction

  // ROM source buffers: first enable only primes them.
  logic [N-1:0] sp, sv;
  logic [N-1:0] inj = '0;
  flit_t        sd [N];
  int           sk [N];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
      sv <= '0;
      for (int i = 0; i < N; i++) begin
        sd[i] <= '0;
        sk[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        sv[i] <= 1'b0;
        if (src_en[i]) begin
          if (!sp[i]) begin
            sp[i] <= 1'b1;
          end else begin
            sv[i] <= 1'b1;
            sd[i] <= rom(i, sk[i]);
            sk[i] <= sk[i] + 1;
          end
        end
      end
    end
  end

  always_comb begin
    src_valid = sv | inj;
    for (int i = 0; i < N; i++)
      src_data[i*DW +: DW] = sd[i];
  end

  bit auto_ret = 1'b0;
  bit pulse = 1'b0;

  initial forever begin
    @(posedge clk);
    #2;
    credit_ret = auto_ret ? out_valid : pulse;
  end

  // Reference model
  int     mk [N];
  int     prim [N];
  int     nout [N];
  bit     mp [N];
  int     nstream, nouts, last_s;
  int     grants0, run0, mcred;
  logic   hv [2];
  flit_t  hd [2];
  int     hs [2];
  flit_t  last_d;
  bit     err_exp = 1'b0;
  logic [N-1:0] prev_en;
  flit_t  got [$];

  always @(negedge clk) begin
    int s, e, p, tk;
    bit nv, fnd;
    flit_t nd;
    if (!rst) begin
      chk("rst_en", src_en, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_od", out_data, 0);
      chk("rst_done", all_done, 0);
      chk("rst_err", err, 0);
      for (int i = 0; i < N; i++) begin
        mk[i] = 0; prim[i] = 0;
        nout[i] = 0; mp[i] = 1'b0;
      end
      nstream = 0; nouts = 0; last_s = -1;
      grants0 = 0; run0 = 0; mcred = C;
      hv[0] = 0; hv[1] = 0;
      hd[0] = '0; hd[1] = '0;
      hs[0] = 0; hs[1] = 0;
      last_d = '0; prev_en = '0;
      got.delete();
    end else begin
      chk("onehot", 32'($onehot0(src_en)), 1);
      chk("out_valid", out_valid, hv[1]);
      if (hv[1]) begin
        chk("out_data", out_data, hd[1]);
        nouts++;
        nout[hs[1]]++;
        got.push_back(out_data);
        last_d = hd[1];
      end else begin
        chk("out_hold", out_data, last_d);
      end
      chk("err", err, err_exp);
      if (all_done) chk("done_en", src_en, 0);
      nv = 0; nd = '0; s = 0; tk = 0;
      if (src_en != 0) begin
        for (int i = 0; i < N; i++)
          if (src_en[i]) s = i;
        if (s != last_s) begin
          p = (last_s < 0) ? 0 : (last_s + 1) % N;
          e = -1; fnd = 0;
          for (int o = 0; o < N; o++) begin
            if (!fnd && mk[(p + o) % N] < D) begin
              e = (p + o) % N;
              fnd = 1;
            end
          end
          chk("rr_order", s, e);
          last_s = s;
        end
        if (src_en[0] && !prev_en[0]) begin
          grants0++;
          run0 = 0;
        end
        if (!mp[s]) begin
          mp[s] = 1'b1;
          prim[s]++;
        end else begin
          chk("credit_avail", 32'(mcred > 0), 1);
          nv = 1;
          nd = rom(s, mk[s]);
          mk[s]++;
          nstream++;
          tk = 1;
          if (s == 0) run0++;
        end
      end
      hv[1] = hv[0]; hd[1] = hd[0]; hs[1] = hs[0];
      hv[0] = nv;    hd[0] = nd;    hs[0] = s;
      mcred = mcred - tk + int'(credit_ret);
      if (mcred > C) mcred = C;
      prev_en = src_en;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    start = 1'b0;
    auto_ret = 1'b0;
    err_exp = 1'b0;
    inj = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic scen1();
    logic [3:0]  seq [13];
    logic [19:0] lit [4];
    seq = '{0, 0, 1, 1, 1, 1, 1, 0, 2, 2, 2, 2, 2};
    lit = '{20'h01010, 20'h01021,
            20'h01032, 20'h01043};
    auto_ret = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("s1_en_seq", src_en, seq[i]);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      chk("s1_data",
          (got.size() > i) ? 32'(got[i]) : 32'hDEAD,
          lit[i]);
  endtask

  task automatic run_to_done(input string nm);
    int cyc;
    cyc = 0;
    while (!all_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, all_done, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("total_outs", nouts, N * D);
    for (int i = 0; i < N; i++)
      chk("per_src_outs", nout[i], D);
    chk("final_en", src_en, 0);
  endtask

  initial begin
    int cyc;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_done", all_done, 0);

    // 1: priming then quota-sized grants
    do_reset();
    scen1();

    // 2: no credit returns
    do_reset();
    @(posedge clk);
    #2;
    start = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("s2_stall4", nstream, 4);
    chk("s2_en_low", src_en, 0);
    @(negedge clk); pulse = 1'b1;
    @(negedge clk); pulse = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("s2_one_more", nstream, 5);
    chk("s2_en_low2", src_en, 0);

    // 3: full run
    do_reset();
    auto_ret = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b1;
    run_to_done("s3_done");
    chk("s3_grants0", grants0, 8);
    chk("s3_last_run0", run0, 2);

    // 4: start dropped mid-grant
    do_reset();
    auto_ret = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (mk[0] < 2 && cyc < 50);
    chk("s4_two_flits", mk[0], 2);
    @(posedge clk);
    #2;
    start = 1'b0;
    #1;
    chk("s4_en_drop", src_en, 0);
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (src_en == 0 && cyc < 20);
    chk("s4_resume_src", src_en, 4'b0010);
    #1;
    chk("s4_src0_flits", mk[0], 2);
    run_to_done("s4_done");
    for (int i = 0; i < N; i++)
      chk("s4_prime_once", prim[i], 1);

    // 5: async reset mid-stream
    do_reset();
    auto_ret = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async_en", src_en, 0);
    chk("s5_async_ov", out_valid, 0);
    chk("s5_async_od", out_data, 0);
    chk("s5_async_done", all_done, 0);
    start = 1'b0;
    auto_ret = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    scen1();

    // 6: protocol checker
    do_reset();
    @(posedge clk);
    #2;
    inj = 4'b0100;
    @(posedge clk);
    #2;
    inj = '0;
    err_exp = ERR_ON;
    repeat (5) @(negedge clk);
    #1;
    chk("s6_sticky", err, ERR_ON);
    do_reset();
    @(negedge clk); pulse = 1'b1;
    @(negedge clk); pulse = 1'b0;
    @(posedge clk);
    #3;
    err_exp = ERR_ON;
    repeat (3) @(negedge clk);
    #1;
    chk("s6_credit_full", err, ERR_ON);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/inj_sched.md
Name: inj_sched

Overview:
- Injection scheduler for one router local port.
- Shares the port among N_SRC ROM-based traffic source buffers. Each source streams one 20-bit flit per enabled cycle, with its valid one cycle after enable, and ignores its first enable after reset (priming cycle).
- Grants sources round-robin with a per-grant quota of flits.
- Gates enables on downstream credits and merges the selected stream onto a single registered output.

Parameters:
- N_SRC, 4: number of source buffers (2..8).
- DW, 20: flit width.
- SRC_DEPTH, 30: flits held by each source; a source is exhausted after this many.
- QUANTUM, 4: maximum flits per grant before rotating to the next source.
- CREDITS, 4: downstream local-input FIFO depth; initial credit count.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: level; scheduler runs while high.
- src_en, output, N_SRC: enable to each source; at most one bit high (one-hot or zero).
- src_data, input, N_SRC*DW: source dataouts; source i occupies bits [i*DW +: DW].
- src_valid, input, N_SRC: source out_valid.
- credit_ret, input, 1: one downstream slot freed this cycle.
- out_data, output, DW: merged flit, registered.
- out_valid, output, 1: out_data valid, registered.
- all_done, output, 1: every source exhausted.
- err, output, 1: sticky protocol error; tied 0 unless ERR_CHK_EN.

Behaviour:
- Reset values:
  - src_en=0, out_data=0, out_valid=0, all_done=0, err=0.
  - credit=CREDITS, rr_ptr=0; all primed, word_cnt and quota_cnt cleared.
  - state=IDLE.
- FSM states: IDLE, SELECT, PRIME, STREAM, DONE.
- IDLE: stay while start=0. On start=1 go to SELECT.
- SELECT (1 cycle):
  - Scan from rr_ptr upward, with wrap, for the first source with word_cnt<SRC_DEPTH.
  - None found: go to DONE.
  - Found: latch it as cur, clear quota_cnt, set rr_ptr=cur+1 (mod N_SRC). Go to PRIME if primed[cur]=0, else STREAM.
- PRIME (1 cycle): src_en[cur]=1, no credit used, set primed[cur]. Go to STREAM.
- STREAM:
  - src_en[cur] = start & (credit>0) & (quota_cnt<QUANTUM) & (word_cnt[cur]<SRC_DEPTH). This is combinational from registered state.
  - Each enabled cycle: credit−1, quota_cnt+1, word_cnt[cur]+1.
  - If that cycle makes quota_cnt==QUANTUM or word_cnt[cur]==SRC_DEPTH, the next state is SELECT.
  - credit==0: hold in STREAM with src_en low (stall). The source pauses and stays primed.
- start deasserted in any state except DONE: src_en drops the same cycle and the next state is IDLE.
  - word_cnt, primed and rr_ptr are retained; quota resets on the next SELECT.
- DONE: all_done=1, src_en=0. Terminal until reset.
- Credit update: credit_next = credit − used + credit_ret.
  - Simultaneous use and return: net 0.
  - A return at credit==CREDITS saturates at CREDITS.
- Output pipeline:
  - sel_d registers cur and pend_d registers "enabled this cycle".
  - On the next cycle, out_valid <= src_valid[sel_d] & pend_d and out_data <= src_data[sel_d].
  - Enable-to-out_valid latency is 2 cycles.
  - When out_valid=0, out_data holds its last value.
- Widths:
  - word_cnt is clog2(SRC_DEPTH+1) bits per source.
  - quota_cnt is clog2(QUANTUM+1) bits.
  - credit is clog2(CREDITS+1) bits.
- Reset mid-stream: all state is cleared immediately. The sources are reset by the same rst, so priming is required again.

Optional Feature:
- Macro INJ_SCHED_ERR_CHK_EN.
- Defined: err is set, and stays set until reset, on any of:
  - src_valid[i]=1 where i is not sel_d or pend_d=0;
  - src_valid[sel_d]=0 when pend_d=1 in a non-priming cycle;
  - credit_ret arriving when credit==CREDITS.
- Not defined: the checker logic is absent and err is a constant 0.

Decomposition:
- Package inj_pkg holds:
  - the FSM state enum;
  - the DW=20 flit typedef;
  - field constants: dest_local bits [3:0], payload bits [19:4];
  - the clog2 helper.
- One sub-module, inj_rr_pick: combinational round-robin first-eligible finder. Inputs: eligible mask and rr_ptr. Outputs: index and found.

Test Plan:
1. Reset, start=1, CREDITS=4, credit_ret tied 1 each cycle after each accepted flit.
   - Expected: src0 primed for 1 cycle, then 4 flits from src0, SELECT, then src1 primed plus 4 flits.
   - out_data sequence for src0 begins 01010, 01021, 01032, 01043.
   - out_valid goes high exactly 2 cycles after each non-priming src_en.
2. credit_ret=0 throughout, start=1.
   - Expected: exactly 4 enabled STREAM cycles, then src_en stays 0 indefinitely.
   - One credit_ret pulse releases exactly one more flit.
3. Run to completion with N_SRC=4, SRC_DEPTH=30, continuous credit return.
   - Expected: 120 out_valid pulses total, no duplicate flits, all_done=1, src_en=0.
   - src0 exhausts after 8 grants (7×4+2): its last grant carries 2 flits.
4. Drop start for 5 cycles mid-STREAM (after 2 flits of a grant), then reassert.
   - Expected: src_en falls the same cycle, no flit lost.
   - Resume goes through SELECT to the next source; no re-prime of already primed sources.
5. Assert rst low mid-STREAM.
   - Expected: all outputs go to 0 asynchronously; after release, behaviour is identical to scenario 1.
6. With INJ_SCHED_ERR_CHK_EN defined:
   - Force src_valid[2]=1 while sel_d=0: err=1 next cycle and stays set.
   - Pulse credit_ret at full credit: err=1.
   - With the macro undefined: err stays 0.
